fsm_sw_ctrl: RTL
================

Name: fsm_sw_ctrl

Overview:
Parametrised successor to the switch-driven 5-state controller. It adds a 2-flop input synchroniser, selectable level/rising-edge event detection, a per-state dwell timeout that returns the FSM to S0, a freeze input, and a saturating transition counter. It sits between the board switches/keys and the display/status logic, driving State and Z.

Parameters:
EDGE_MODE, 0, 0 = switch events are synchronised levels; 1 = events are single-cycle rising edges of the synchronised switches.
TIMEOUT, 200, dwell limit in clock cycles for any non-S0 state; 0 disables the timeout.
TMO_W, 8, width of the dwell counter; TIMEOUT must be ≤ 2^TMO_W-1.
CNT_W, 8, width of the transition counter.

Ports:
KEY0  input  1  clock, rising edge.
SW0_N  input  1  synchronous active-low reset.
SW  input  4  raw switches; SW[0]=SW1, SW[1]=SW2, SW[2]=SW3, SW[3]=SW4; asynchronous to KEY0.
FREEZE  input  1  synchronous; when high, State, Z, dwell counter and transition counter hold.
CLR_CNT  input  1  synchronous; clears trans_cnt.
State  output  3  registered present state.
Z  output  2  registered Moore output.
timeout  output  1  one-cycle pulse when a dwell timeout forces S0.
trans_cnt  output  CNT_W  saturating count of state changes.

Behaviour:
- Reset (SW0_N=0 at a KEY0 edge) sets: State=S0(3'd0), Z=2'b00, timeout=0, trans_cnt=0, dwell=0, sync stages=0. The edge-detect previous-value register resets to 4'b1111, so a switch held high through reset produces no event.
- Reset has priority over FREEZE and CLR_CNT.
- Synchroniser: SW → s1 → s2, two flops. Event vector ev = s2 (EDGE_MODE=0) or s2 & ~prev, with prev<=s2 (EDGE_MODE=1). The synchroniser and prev keep running during FREEZE.
- Latency: a SW change sampled at edge n appears in s2 after edge n+1. State/Z update at edge n+2.
- Encoding: S0=0, S1=1, S2=2, S3=3, S4=4. Codes 5–7 go to S0 on the next edge and are not counted.
- Transitions (listed in priority order, else hold):
  S0: ev[1]→S1; ev[0]→S3.
  S1: ev[0]→S2.
  S2: ev[0]→S1; ev[3]→S3.
  S3: ev[0]→S1; ev[2]→S4.
  S4: ev[0]→S1.
- Timeout:
  - dwell clears on any state change and in S0. Otherwise it increments by 1 per non-frozen cycle, saturating.
  - When TIMEOUT≠0, State≠S0, no switch transition is taken this cycle and dwell==TIMEOUT-1, then: next State=S0, timeout=1 for exactly that one cycle (coincident with State=S0).
  - A switch transition in the same cycle wins; dwell then clears and timeout stays 0.
- Z (registered with State, same-cycle consistent): S0→00, S1→01, S2→10, S3→11, S4→10.
- trans_cnt:
  - +1 on every edge where next State ≠ State (timeouts included), saturating at all-ones.
  - CLR_CNT clears it; if CLR_CNT and a transition occur in the same cycle, the result is 0.
  - FREEZE blocks counting but not CLR_CNT.
- FREEZE=1: no transitions and no timeout pulse. Events that occur during FREEZE in EDGE_MODE=1 are lost.
- Reset mid-operation: the next edge with SW0_N=0 returns all outputs to their reset values regardless of state or dwell.

Test Plan:
1. Reset, EDGE_MODE=0; SW=4'b0010 (SW2) held → State=1, Z=01 on the 3rd edge after the change; trans_cnt=1.
2. EDGE_MODE=0, from S0: SW1 high → S3. Then SW1 low, SW3 high → S4, Z=10. Then SW1 high → S1; trans_cnt=3.
3. TIMEOUT=5, enter S1, SW=0 → State=0 and timeout=1 exactly 5 cycles after entering S1; next cycle timeout=0; trans_cnt incremented.
4. TIMEOUT=5, in S2 on the dwell==4 cycle an SW1 event arrives → State=S1, timeout stays 0, dwell restarts.
5. EDGE_MODE=1: SW1 held high through reset release → no transition. Toggle SW1 0→1 once → exactly one transition S0→S3, with no further movement while held.
6. CNT_W=2: drive 5 transitions → trans_cnt=3 (saturated). CLR_CNT=1 with a simultaneous transition → 0. FREEZE=1 with SW2 asserted → State unchanged.

Source files
------------

// File: rtl/fsm_sw_ctrl_if.sv
// Switch/status bundle of the switch-driven controller: raw switch and control
// inputs toward the FSM, registered state/status back to the display side.
interface fsm_sw_ctrl_if #(
  parameter int CNT_W = 8
);
  logic [3:0]       SW;
  logic             FREEZE;
  logic             CLR_CNT;
  logic [2:0]       State;
  logic [1:0]       Z;
  logic             timeout;
  logic [CNT_W-1:0] trans_cnt;

  modport master (
    output SW, FREEZE, CLR_CNT,
    input  State, Z, timeout, trans_cnt
  );

  modport slave (
    input  SW, FREEZE, CLR_CNT,
    output State, Z, timeout, trans_cnt
  );
endinterface

// File: rtl/fsm_sw_ctrl.sv
// Switch-driven 5-state controller: synchronised switch events, per-state dwell
// timeout back to S0, freeze control and a saturating transition counter.
module fsm_sw_ctrl #(
  parameter int EDGE_MODE = 0,
  parameter int TIMEOUT   = 200,
  parameter int TMO_W     = 8,
  parameter int CNT_W     = 8
) (
  input  logic          KEY0,
  input  logic          SW0_N,
  fsm_sw_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LAST  = (TIMEOUT == 0) ? {TMO_W{1'b0}} : TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] DWELL_MAX = {TMO_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [3:0]       s1_r;
  logic [3:0]       s2_r;
  logic [3:0]       prev_r;
  logic             v1_r;
  logic             v2_r;
  state_t           state_r;
  logic [1:0]       z_r;
  logic             timeout_r;
  logic [TMO_W-1:0] dwell_r;
  logic [CNT_W-1:0] cnt_r;

  logic [3:0]       ev_s;
  logic             take_s;
  state_t           dest_s;
  state_t           next_s;
  logic             valid_s;
  logic             tmo_hit_s;
  logic             change_s;

  function automatic logic [1:0] z_of(input state_t s);
    case (s)
      S0:      z_of = 2'b00;
      S1:      z_of = 2'b01;
      S2:      z_of = 2'b10;
      S3:      z_of = 2'b11;
      S4:      z_of = 2'b10;
      default: z_of = 2'b00;
    endcase
  endfunction

  // Two-flop synchroniser plus edge-detect history; v1/v2 mark stages holding real samples.
  always_ff @(posedge KEY0) begin
    if (!SW0_N) begin
      s1_r   <= 4'b0000;
      s2_r   <= 4'b0000;
      prev_r <= 4'b1111;
      v1_r   <= 1'b0;
      v2_r   <= 1'b0;
    end else begin
      s1_r   <= bus.SW;
      s2_r   <= s1_r;
      v1_r   <= 1'b1;
      v2_r   <= v1_r;
      // prev stays all-ones until s2 carries a real sample, so a switch held through reset is not an edge
      prev_r <= v2_r ? s2_r : 4'b1111;
    end
  end

  // Switch-event transition selection and dwell-timeout decision.
  always_comb begin
    ev_s   = (EDGE_MODE != 0) ? (s2_r & ~prev_r) : s2_r;
    take_s = 1'b0;
    dest_s = state_r;
    case (state_r)
      S0: begin
        if (ev_s[1])      begin take_s = 1'b1; dest_s = S1;      end
        else if (ev_s[0]) begin take_s = 1'b1; dest_s = S3;      end
        else              begin take_s = 1'b0; dest_s = state_r; end
      end
      S1: begin
        if (ev_s[0])      begin take_s = 1'b1; dest_s = S2;      end
        else              begin take_s = 1'b0; dest_s = state_r; end
      end
      S2: begin
        if (ev_s[0])      begin take_s = 1'b1; dest_s = S1;      end
        else if (ev_s[3]) begin take_s = 1'b1; dest_s = S3;      end
        else              begin take_s = 1'b0; dest_s = state_r; end
      end
      S3: begin
        if (ev_s[0])      begin take_s = 1'b1; dest_s = S1;      end
        else if (ev_s[2]) begin take_s = 1'b1; dest_s = S4;      end
        else              begin take_s = 1'b0; dest_s = state_r; end
      end
      S4: begin
        if (ev_s[0])      begin take_s = 1'b1; dest_s = S1;      end
        else              begin take_s = 1'b0; dest_s = state_r; end
      end
      default: begin
        take_s = 1'b1;
        dest_s = S0;
      end
    endcase

    valid_s   = (state_r <= S4);
    tmo_hit_s = (TIMEOUT != 0) && valid_s && (state_r != S0) && !take_s && (dwell_r == TMO_LAST);

    if (take_s) begin
      next_s = dest_s;
    end else if (tmo_hit_s) begin
      next_s = S0;
    end else begin
      next_s = state_r;
    end

    // recovery from an illegal code is not a counted state change
    change_s = valid_s && (next_s != state_r);
  end

  // Controller state, Moore output, timeout pulse, dwell and transition counters.
  always_ff @(posedge KEY0) begin
    if (!SW0_N) begin
      state_r   <= S0;
      z_r       <= 2'b00;
      timeout_r <= 1'b0;
      dwell_r   <= {TMO_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
    end else begin
      if (bus.CLR_CNT) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (!bus.FREEZE && change_s && (cnt_r != CNT_MAX)) begin
        cnt_r <= cnt_r + CNT_W'(1'b1);
      end else begin
        cnt_r <= cnt_r;
      end

      if (bus.FREEZE) begin
        timeout_r <= 1'b0;
      end else begin
        state_r   <= next_s;
        z_r       <= z_of(next_s);
        timeout_r <= tmo_hit_s;
        if ((next_s != state_r) || (state_r == S0)) begin
          dwell_r <= {TMO_W{1'b0}};
        end else if (dwell_r != DWELL_MAX) begin
          dwell_r <= dwell_r + TMO_W'(1'b1);
        end else begin
          dwell_r <= dwell_r;
        end
      end
    end
  end

  assign bus.State     = state_r;
  assign bus.Z         = z_r;
  assign bus.timeout   = timeout_r;
  assign bus.trans_cnt = cnt_r;

endmodule
